// File: rtl/fifo_rom_lookup_engine.sv
`timescale 1ns/1ps
// Pops {tag, idx} words from a first-word-fall-through FIFO, reads the ROM at base_addr+idx and
// returns {tag, rom_data} in issue order through a result buffer, with bounded outstanding lookups.
module fifo_rom_lookup_engine #(
    parameter int TAG_W    = 4,
    parameter int IDX_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_OUT  = 4,
    parameter int SAT_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         fifo_empty,
    input  logic [TAG_W+IDX_W-1:0]       fifo_data,
    output logic                         fifo_rd_en,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         rom_ce,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    input  logic                         rom_valid,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [TAG_W+DATA_W-1:0]      res_data,
    output logic                         busy,
    output logic [$clog2(MAX_OUT+1)-1:0] occupancy,
    output logic                         err_unexp
);

    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int RES_W = TAG_W + DATA_W;

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_OUT);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [OCC_W-1:0]  r_occ;

    logic [TAG_W-1:0]  r_tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  r_tag_wr;
    logic [PTR_W-1:0]  r_tag_rd;
    logic [OCC_W-1:0]  r_tag_cnt;

    logic [RES_W-1:0]  r_res_mem [MAX_OUT];
    logic [PTR_W-1:0]  r_res_wr;
    logic [PTR_W-1:0]  r_res_rd;
    logic [OCC_W-1:0]  r_res_cnt;

    logic              r_rom_ce;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_err;

    logic              w_issue;
    logic              w_pop;
    logic              w_rsp_ok;
    logic              w_rsp_bad;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_idx_ext;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_addr;

    assign w_tag = fifo_data[TAG_W+IDX_W-1:IDX_W];

    generate
        if (IDX_W >= ADDR_W) begin : g_idx_trunc
            assign w_idx_ext = fifo_data[ADDR_W-1:0];
        end else begin : g_idx_zext
            assign w_idx_ext = {{(ADDR_W-IDX_W){1'b0}}, fifo_data[IDX_W-1:0]};
        end
    endgenerate

    // One extra bit of headroom so the carry decides between wrap and saturate.
    assign w_sum  = {1'b0, base_addr} + {1'b0, w_idx_ext};
    assign w_addr = ((SAT_MODE != 0) && w_sum[ADDR_W]) ? {ADDR_W{1'b1}} : w_sum[ADDR_W-1:0];

    // Credits come only from the registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_issue   = rst_n && (r_state == S_RUN) && enable && !fifo_empty && (r_occ < OCC_MAX);
    assign w_pop     = rst_n && (r_res_cnt != '0) && res_ready;
    assign w_rsp_ok  = rst_n && rom_valid && (r_tag_cnt != '0);
    assign w_rsp_bad = rst_n && rom_valid && (r_tag_cnt == '0);

    assign fifo_rd_en = w_issue;
    assign rom_ce     = r_rom_ce;
    assign rom_addr   = r_rom_addr;
    assign res_valid  = (r_res_cnt != '0);
    assign res_data   = (r_res_cnt != '0) ? r_res_mem[r_res_rd] : '0;
    assign busy       = (r_state != S_IDLE);
    assign occupancy  = r_occ;
    assign err_unexp  = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (enable)         r_state <= S_RUN;
                S_RUN:   if (!enable)        r_state <= S_DRAIN;
                S_DRAIN: if (r_occ == '0)    r_state <= S_IDLE;
                default:                     r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_ce   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_rom_ce <= w_issue;
            if (w_issue) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_rsp_bad) begin
            r_err <= 1'b1;
        end
    end

    // Tag queue: written at issue, consumed by each accepted ROM response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_issue)  r_tag_wr <= r_tag_wr + PTR_ONE;
            if (w_rsp_ok) r_tag_rd <= r_tag_rd + PTR_ONE;
            case ({w_issue, w_rsp_ok})
                2'b10:   r_tag_cnt <= r_tag_cnt + OCC_ONE;
                2'b01:   r_tag_cnt <= r_tag_cnt - OCC_ONE;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_tag_wr] <= w_tag;
        end
    end

    // Result buffer: tag and data counts together never exceed occupancy, so no overflow check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_rsp_ok) r_res_wr <= r_res_wr + PTR_ONE;
            if (w_pop)    r_res_rd <= r_res_rd + PTR_ONE;
            case ({w_rsp_ok, w_pop})
                2'b10:   r_res_cnt <= r_res_cnt + OCC_ONE;
                2'b01:   r_res_cnt <= r_res_cnt - OCC_ONE;
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_ok) begin
            r_res_mem[r_res_wr] <= {r_tag_mem[r_tag_rd], rom_data};
        end
    end

endmodule
